// File: rtl/ahbl_wait_mem_if.sv
// AHB-Lite bus bundle between one manager and the ahbl_wait_mem subordinate.
// hready is the bus-wide ready (driven by the interconnect / manager side);
// hready_resp is the subordinate's own ready response.
interface ahbl_wait_mem_if #(
  parameter int W_ADDR = 32
);
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;

  modport master (
    output haddr, hwrite, htrans, hsize, hready, hwdata,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, htrans, hsize, hready, hwdata,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahbl_wait_mem.sv
// ahbl_wait_mem: AHB-Lite word memory with programmable wait states.
// - Each captured transfer stalls for wait_states cycles (sampled with the
//   address phase), then completes OKAY; writes commit their byte lanes at the
//   end of the completion cycle, reads present data during it.
// - Read data is loaded into hrdata_r on the edge that precedes completion,
//   with forwarding from a write committing on that same edge so that
//   write-then-read of one word returns the new data.
// - Optional build macro AHBL_WAIT_MEM_ERR_INJECT_EN: out-of-range or
//   misaligned transfers get the two-cycle ERROR response and have no effect.
//   Without it hresp is tied low, addresses wrap modulo DEPTH and low address
//   bits are force-aligned to the transfer size.
module ahbl_wait_mem #(
  parameter int DEPTH     = 1024,
  parameter int W_ADDR    = 32,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  ahbl_wait_mem_if.slave        ahbl,
  input  logic [3:0]            wait_states
);

  localparam int W_IDX = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2
  } state_t;

  // Write-lane merge: lanes selected by mask take the new data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  // Byte-lane enable for a transfer of normalised size at the given low address.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << lo;
      2'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  logic [31:0]      mem_r [0:DEPTH-1];

  state_t           state_r;
  logic             hready_resp_r;
  logic [31:0]      hrdata_r;
  logic             pend_r;
  logic             dwrite_r;
  logic [W_IDX-1:0] didx_r;
  logic [3:0]       dmask_r;
  logic [3:0]       cnt_r;

  logic             capture_s;
  logic [1:0]       size_s;
  logic [1:0]       addr_lo_s;
  logic [W_IDX-1:0] idx_s;
  logic             commit_s;
  logic [W_IDX-1:0] rd_idx_s;
  logic [31:0]      mem_word_s;
  logic [31:0]      rd_word_s;

`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
  logic             hresp_r;
  logic             derr_r;
  logic             err_s;
`else
  logic             unused_addr_s;
`endif

  // A new address phase is taken only when the bus is ready and we are not stalling.
  assign capture_s = ahbl.hready && ahbl.htrans[1] && hready_resp_r;
  assign idx_s     = ahbl.haddr[W_IDX+1:2];

`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
  assign commit_s  = pend_r && hready_resp_r && dwrite_r && !derr_r;
  assign ahbl.hresp = hresp_r;
`else
  assign commit_s  = pend_r && hready_resp_r && dwrite_r;
  assign ahbl.hresp = 1'b0;
  // Upper address bits are deliberately ignored so that addresses wrap.
  assign unused_addr_s = ^{1'b0, ahbl.haddr[W_ADDR-1:W_IDX+2]};
`endif

  assign ahbl.hready_resp = hready_resp_r;
  assign ahbl.hrdata      = hrdata_r;

  // Normalise hsize (anything above word is a word) and force-align the low address bits.
  always_comb begin
    size_s    = 2'd2;
    addr_lo_s = 2'b00;
    if (ahbl.hsize[2] || (ahbl.hsize[1:0] == 2'd3)) begin
      size_s = 2'd2;
    end else begin
      size_s = ahbl.hsize[1:0];
    end
    case (size_s)
      2'd0:    addr_lo_s = ahbl.haddr[1:0];
      2'd1:    addr_lo_s = {ahbl.haddr[1], 1'b0};
      default: addr_lo_s = 2'b00;
    endcase
  end

`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
  // Error classification of the address phase: out of range or misaligned for its size.
  always_comb begin
    err_s = 1'b0;
    if (|ahbl.haddr[W_ADDR-1:W_IDX+2]) begin
      err_s = 1'b1;
    end else begin
      case (size_s)
        2'd0:    err_s = 1'b0;
        2'd1:    err_s = ahbl.haddr[0];
        default: err_s = |ahbl.haddr[1:0];
      endcase
    end
  end
`endif

  // Read-data source: live address on a zero-wait capture, held index at the end of a stall,
  // with forwarding of a write that commits on the same edge.
  always_comb begin
    rd_idx_s = didx_r;
    if (state_r == ST_IDLE) begin
      rd_idx_s = idx_s;
    end else begin
      rd_idx_s = didx_r;
    end
    mem_word_s = mem_r[rd_idx_s];
    rd_word_s  = (commit_s && (didx_r == rd_idx_s))
               ? merge_lanes(mem_word_s, ahbl.hwdata, dmask_r)
               : mem_word_s;
  end

  generate
    if (INIT_ZERO) begin : g_mem_zero
      // Memory array: cleared by reset, written on a committing completion cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'd0;
          end
        end else if (commit_s) begin
          mem_r[didx_r] <= merge_lanes(mem_r[didx_r], ahbl.hwdata, dmask_r);
        end
      end
    end else begin : g_mem_keep
      // Memory array: contents survive reset, but a write cut short by reset is dropped.
      always_ff @(posedge clk) begin
        if (!rst && commit_s) begin
          mem_r[didx_r] <= merge_lanes(mem_r[didx_r], ahbl.hwdata, dmask_r);
        end
      end
    end
  endgenerate

  // Transfer FSM: captures address phases, counts wait states, drives the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      hready_resp_r <= 1'b1;
      hrdata_r      <= 32'd0;
      pend_r        <= 1'b0;
      dwrite_r      <= 1'b0;
      didx_r        <= '0;
      dmask_r       <= 4'd0;
      cnt_r         <= 4'd0;
`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
      hresp_r       <= 1'b0;
      derr_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            pend_r   <= 1'b1;
            dwrite_r <= ahbl.hwrite;
            didx_r   <= idx_s;
            dmask_r  <= lane_mask(size_s, addr_lo_s);
`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
            derr_r   <= err_s;
            if (err_s) begin
              state_r       <= ST_ERR1;
              hready_resp_r <= 1'b0;
              hresp_r       <= 1'b1;
            end else if (wait_states != 4'd0) begin
              state_r       <= ST_WAIT;
              hready_resp_r <= 1'b0;
              hresp_r       <= 1'b0;
              cnt_r         <= wait_states - 4'd1;
            end else begin
              hready_resp_r <= 1'b1;
              hresp_r       <= 1'b0;
              if (!ahbl.hwrite) begin
                hrdata_r <= rd_word_s;
              end
            end
`else
            if (wait_states != 4'd0) begin
              state_r       <= ST_WAIT;
              hready_resp_r <= 1'b0;
              cnt_r         <= wait_states - 4'd1;
            end else begin
              hready_resp_r <= 1'b1;
              if (!ahbl.hwrite) begin
                hrdata_r <= rd_word_s;
              end
            end
`endif
          end else begin
            pend_r        <= 1'b0;
            hready_resp_r <= 1'b1;
`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
            hresp_r       <= 1'b0;
            derr_r        <= 1'b0;
`endif
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r       <= ST_IDLE;
            hready_resp_r <= 1'b1;
            if (!dwrite_r) begin
              hrdata_r <= rd_word_s;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
`ifdef AHBL_WAIT_MEM_ERR_INJECT_EN
        ST_ERR1: begin
          // Second error cycle: ready rises with hresp still high.
          state_r       <= ST_IDLE;
          hready_resp_r <= 1'b1;
          hresp_r       <= 1'b1;
        end
`endif
        default: begin
          state_r       <= ST_IDLE;
          hready_resp_r <= 1'b1;
          pend_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule
